mem_bus_arbiter: RTL and testbench
==================================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 32, address width; DATA_W, default 32, data width; TIMEOUT_CYC, default 16, bus-stall cycles before abort.
REQ-002 Ports SHALL be (name direction width meaning):
  clk  in  1  system clock, rising edge
  rst  in  1  synchronous reset, active-high
  m0_req  in  1  master 0 (CPU) access request
  m0_we  in  1  master 0 write (1) / read (0)
  m0_addr  in  ADDR_W  master 0 address
  m0_wdata  in  DATA_W  master 0 write data
  m0_rdata  out  DATA_W  master 0 read data, valid with m0_ack
  m0_ack  out  1  master 0 transfer complete, 1-cycle pulse
  m0_err  out  1  master 0 transfer aborted, valid with m0_ack
  m1_req, m1_we, m1_addr, m1_wdata, m1_rdata, m1_ack, m1_err  same as m0_*, master 1 (UART loader/DMA)
  bus_addr  out  ADDR_W  address to memory map decoder
  bus_wdata  out  DATA_W  write data to decoder
  bus_re  out  1  read strobe
  bus_we  out  1  write strobe
  bus_rdata  in  DATA_W  read data from decoder
  bus_ready  in  1  slave completes access this cycle
  owner  out  1  index of master holding the bus

Function
REQ-003 FSM states SHALL be IDLE, ACCESS, RESP; IDLE->ACCESS when any req=1 at the edge; ACCESS->RESP on bus_ready=1 (or timeout); RESP->IDLE unconditionally.
REQ-004 In IDLE, winner SHALL be chosen round-robin: sole requester wins; with both requesting, master opposite last winner wins; last winner after reset SHALL be 1 (m0 wins first tie).
REQ-005 On IDLE->ACCESS, winner's we/addr/wdata SHALL be latched; bus outputs SHALL come only from latched values; requester changes during ACCESS/RESP SHALL be ignored.
REQ-006 In ACCESS, bus_re=~we_latched and bus_we=we_latched SHALL be held every cycle until exit; both 0 in IDLE and RESP.
REQ-007 bus_rdata SHALL be registered on the ACCESS cycle with bus_ready=1 and presented on winner's rdata during RESP; the non-winner's rdata SHALL hold its previous value.
REQ-008 Winner's ack SHALL be 1 for exactly the RESP cycle; minimum latency req sampled -> ack = 2 cycles (bus_ready=1 on first ACCESS cycle).
REQ-009 A requester SHALL hold req until ack; req still high in the IDLE after RESP starts a new arbitration (back-to-back, one IDLE bubble).
REQ-010 owner SHALL equal the latched winner in ACCESS/RESP and last winner in IDLE.
REQ-011 The non-granted master SHALL see ack=0, err=0 throughout.
REQ-012 Writes SHALL return rdata unchanged and err=0 unless aborted.

Reset
REQ-013 rst=1 SHALL force IDLE, last winner=1, all ack/err/re/we=0, rdata=0, bus_addr/bus_wdata=0, owner=0, timeout counter=0, regardless of state.
REQ-014 rst asserted mid-ACCESS SHALL drop strobes on the next edge with no ack issued.

Configuration
REQ-015 Macro MEM_ARB_TIMEOUT_EN defined: counter SHALL count ACCESS cycles; if bus_ready is still 0 after TIMEOUT_CYC cycles, FSM SHALL go to RESP with err=1 and rdata=32'hDEAD_BEEF; counter clears on entering ACCESS.
REQ-016 MEM_ARB_TIMEOUT_EN undefined: ACCESS SHALL wait indefinitely for bus_ready; err outputs tied 0; no counter logic.

Structure
REQ-017 Package mem_arb_pkg SHALL hold the state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2), master index constants M_CPU=0, M_AUX=1, and ARB_ERR_DATA=32'hDEAD_BEEF.
REQ-018 The timeout counter SHALL be a sub-module arb_timeout_counter (clear, enable, expired), instantiated only under MEM_ARB_TIMEOUT_EN.

Verification
REQ-019 m0 read addr 0x1001_0000, bus_ready=1 first ACCESS cycle, bus_rdata=0x1234_5678 -> m0_ack at cycle+2, m0_rdata=0x1234_5678, bus_re one cycle.
REQ-020 m0 and m1 request together, held over 4 transfers -> grants M0,M1,M0,M1; owner tracks; one IDLE bubble between.
REQ-021 m1 write 0xA5 to 0x1001_0024, bus_ready delayed 3 cycles -> bus_we high 4 cycles, m1_ack once, m1_err=0.
REQ-022 MEM_ARB_TIMEOUT_EN, TIMEOUT_CYC=16, bus_ready never -> m0_ack with m0_err=1, m0_rdata=0xDEAD_BEEF after 16 ACCESS cycles; undefined -> no ack after 100 cycles.
REQ-023 rst pulsed during ACCESS -> strobes 0 next cycle, no ack, next tie goes to m0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-master memory bus arbiter: state encoding,
// master indices, abort read-back pattern and the round-robin pick.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_e;

  localparam logic        M_CPU        = 1'b0;
  localparam logic        M_AUX        = 1'b1;
  localparam logic [31:0] ARB_ERR_DATA = 32'hDEAD_BEEF;

  // A lone requester wins; on a tie the master that did not win last time goes.
  function automatic logic rr_pick(input logic req0, input logic req1, input logic last_win);
    logic pick;
    if (req0 && req1) begin
      pick = ~last_win;
    end else if (req1) begin
      pick = M_AUX;
    end else begin
      pick = M_CPU;
    end
    return pick;
  endfunction

endpackage

// File: rtl/arb_timeout_counter.sv
// Counts stalled ACCESS cycles; expired is raised during the TIMEOUT_CYC-th
// consecutive enabled cycle so the FSM can abort on that edge.
module arb_timeout_counter #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_r;

  // Cycle counter: cleared on entry to ACCESS, advances while the access stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (enable && !expired) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign expired = enable && (cnt_r == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter giving a CPU and an auxiliary master one-at-a-time access
// to the memory bus. Define MEM_ARB_TIMEOUT_EN to abort accesses that stall.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ack,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ack,
  output logic              m1_err,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  output logic              bus_re,
  output logic              bus_we,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ready,
  output logic              owner
);

  arb_state_e        state_r, state_nxt_s;
  logic              last_win_r;
  logic              owner_r;
  logic              we_r;
  logic [ADDR_W-1:0] bus_addr_r;
  logic [DATA_W-1:0] bus_wdata_r;
  logic              bus_re_r, bus_we_r;
  logic [DATA_W-1:0] m0_rdata_r, m1_rdata_r;
  logic              m0_ack_r, m1_ack_r;

  logic              grant_s, start_s, done_s, abort_s, timeout_s;
  logic              sel_we_s;
  logic [ADDR_W-1:0] sel_addr_s;
  logic [DATA_W-1:0] sel_wdata_s;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state, grant selection and transfer start/finish strobes.
  always_comb begin
    state_nxt_s = state_r;
    start_s     = 1'b0;
    done_s      = 1'b0;
    abort_s     = 1'b0;
    grant_s     = rr_pick(m0_req, m1_req, last_win_r);
    sel_we_s    = (grant_s == M_AUX) ? m1_we    : m0_we;
    sel_addr_s  = (grant_s == M_AUX) ? m1_addr  : m0_addr;
    sel_wdata_s = (grant_s == M_AUX) ? m1_wdata : m0_wdata;
    case (state_r)
      IDLE: begin
        if (m0_req || m1_req) begin
          state_nxt_s = ACCESS;
          start_s     = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ACCESS: begin
        // A slave answer in the last allowed cycle still wins over the abort.
        if (bus_ready) begin
          state_nxt_s = RESP;
          done_s      = 1'b1;
        end else if (timeout_s) begin
          state_nxt_s = RESP;
          done_s      = 1'b1;
          abort_s     = 1'b1;
        end else begin
          state_nxt_s = ACCESS;
        end
      end
      RESP: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Request latch, bus strobes, per-master read data and acknowledge pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_win_r  <= M_AUX;
      owner_r     <= M_CPU;
      we_r        <= 1'b0;
      bus_addr_r  <= '0;
      bus_wdata_r <= '0;
      bus_re_r    <= 1'b0;
      bus_we_r    <= 1'b0;
      m0_rdata_r  <= '0;
      m1_rdata_r  <= '0;
      m0_ack_r    <= 1'b0;
      m1_ack_r    <= 1'b0;
    end else begin
      if (start_s) begin
        last_win_r  <= grant_s;
        owner_r     <= grant_s;
        we_r        <= sel_we_s;
        bus_addr_r  <= sel_addr_s;
        bus_wdata_r <= sel_wdata_s;
        bus_re_r    <= ~sel_we_s;
        bus_we_r    <= sel_we_s;
      end else if (done_s) begin
        bus_re_r <= 1'b0;
        bus_we_r <= 1'b0;
      end
      m0_ack_r <= done_s && (owner_r == M_CPU);
      m1_ack_r <= done_s && (owner_r == M_AUX);
      // Only the owner's read data moves; writes leave it untouched unless aborted.
      if (done_s && (owner_r == M_CPU)) begin
        if (abort_s) begin
          m0_rdata_r <= DATA_W'(ARB_ERR_DATA);
        end else if (!we_r) begin
          m0_rdata_r <= bus_rdata;
        end
      end
      if (done_s && (owner_r == M_AUX)) begin
        if (abort_s) begin
          m1_rdata_r <= DATA_W'(ARB_ERR_DATA);
        end else if (!we_r) begin
          m1_rdata_r <= bus_rdata;
        end
      end
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  logic m0_err_r, m1_err_r;

  arb_timeout_counter #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (start_s),
    .enable (state_r == ACCESS),
    .expired(timeout_s)
  );

  // Error flags accompany the abort acknowledge for exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      m0_err_r <= 1'b0;
      m1_err_r <= 1'b0;
    end else begin
      m0_err_r <= abort_s && (owner_r == M_CPU);
      m1_err_r <= abort_s && (owner_r == M_AUX);
    end
  end

  assign m0_err = m0_err_r;
  assign m1_err = m1_err_r;
`else
  assign timeout_s = 1'b0;
  assign m0_err    = 1'b0;
  assign m1_err    = 1'b0;
`endif

  assign m0_rdata  = m0_rdata_r;
  assign m1_rdata  = m1_rdata_r;
  assign m0_ack    = m0_ack_r;
  assign m1_ack    = m1_ack_r;
  assign bus_addr  = bus_addr_r;
  assign bus_wdata = bus_wdata_r;
  assign bus_re    = bus_re_r;
  assign bus_we    = bus_we_r;
  assign owner     = owner_r;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: vector table of single transfers,
// plus hand-written timeout/stall, mid-access reset and tie-break sequences.
module tb_mem_bus_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          m0_req = 1'b0, m0_we = 1'b0;
  logic [AW-1:0] m0_addr = '0;
  logic [DW-1:0] m0_wdata = '0;
  logic [DW-1:0] m0_rdata;
  logic          m0_ack, m0_err;
  logic          m1_req = 1'b0, m1_we = 1'b0;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m1_wdata = '0;
  logic [DW-1:0] m1_rdata;
  logic          m1_ack, m1_err;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_re, bus_we;
  logic [DW-1:0] bus_rdata = '0;
  logic          bus_ready = 1'b0;
  logic          owner;

  mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_re(bus_re), .bus_we(bus_we),
    .bus_rdata(bus_rdata), .bus_ready(bus_ready), .owner(owner)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Scoreboard of expected acknowledges, in grant order.
  typedef struct {
    bit            m;
    logic [DW-1:0] rdata;
    bit            err;
  } exp_t;
  exp_t          exp_q[$];
  logic [DW-1:0] model_rd[2];
  int            ack_seen = 0;
  int            ack_cyc_q[$];

  // Slave model: answers after ready_delay stalled cycles (-1 = never).
  int            ready_delay = 0;
  logic [DW-1:0] slave_data = '0;
  int            acc_cnt = 0;
  int            strobe_cnt = 0;
  logic          seen_re = 1'b0, seen_we = 1'b0;
  logic [AW-1:0] seen_addr = '0;
  logic [DW-1:0] seen_wdata = '0;

  always @(negedge clk) begin
    if (bus_re || bus_we) begin
      strobe_cnt++;
      seen_re    = bus_re;
      seen_we    = bus_we;
      seen_addr  = bus_addr;
      seen_wdata = bus_wdata;
      bus_ready  = (acc_cnt == ready_delay);
      bus_rdata  = bus_ready ? slave_data : ~slave_data;
      acc_cnt++;
    end else begin
      bus_ready = 1'b0;
      bus_rdata = 32'h5A5A_5A5A;
      acc_cnt   = 0;
    end
  end

  // Acknowledge monitor: pops the scoreboard on every ack pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (m0_ack || m1_ack)) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ack: got m0_ack=%0b m1_ack=%0b expected none", m0_ack, m1_ack);
      end else begin
        e = exp_q.pop_front();
        chk("ack_master", {63'd0, m1_ack}, {63'd0, e.m});
        chk("single_ack", {63'd0, m0_ack && m1_ack}, 64'd0);
        chk("owner_at_ack", {63'd0, owner}, {63'd0, e.m});
        chk("rdata", e.m ? m1_rdata : m0_rdata, e.rdata);
        chk("err", {63'd0, e.m ? m1_err : m0_err}, {63'd0, e.err});
        chk("other_err", {63'd0, e.m ? m0_err : m1_err}, 64'd0);
        chk("other_rdata_held", e.m ? m0_rdata : m1_rdata, model_rd[!e.m]);
        model_rd[e.m] = e.rdata;
        ack_seen++;
        ack_cyc_q.push_back(cyc);
      end
    end
  end

  task automatic xfer(input bit m, input bit we, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wd, input logic [DW-1:0] rd, input int dly,
                      input logic [DW-1:0] exp_rd, input bit exp_err,
                      input int exp_lat, input int exp_strb);
    int n;
    @(negedge clk);
    ready_delay = dly;
    slave_data  = rd;
    strobe_cnt  = 0;
    exp_q.push_back('{m: m, rdata: exp_rd, err: exp_err});
    if (m) begin
      m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wd;
    end else begin
      m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wd;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(m ? m1_ack : m0_ack) && n < 300);
    m0_req = 1'b0;
    m1_req = 1'b0;
    chk("ack_latency", n, exp_lat);
    chk("strobe_cycles", strobe_cnt, exp_strb);
    chk("bus_addr", seen_addr, addr);
    chk("bus_we", {63'd0, seen_we}, {63'd0, we});
    chk("bus_re", {63'd0, seen_re}, {63'd0, !we});
    if (we) chk("bus_wdata", seen_wdata, wd);
  endtask

  typedef struct {
    bit            m;
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    int            dly;
    logic [DW-1:0] exp_rd;
  } vec_t;
  vec_t vt[6];

  initial begin
    int n;
    int base;
    vt[0] = '{1'b0, 1'b0, 32'h1001_0000, 32'h0000_0000, 32'h1234_5678, 0, 32'h1234_5678};
    vt[1] = '{1'b1, 1'b1, 32'h1001_0024, 32'h0000_00A5, 32'h5555_5555, 3, 32'h0000_0000};
    vt[2] = '{1'b1, 1'b0, 32'h1001_0008, 32'h0000_0000, 32'hCAFE_F00D, 1, 32'hCAFE_F00D};
    vt[3] = '{1'b0, 1'b1, 32'h1001_0010, 32'h0BAD_0001, 32'h7777_7777, 2, 32'h1234_5678};
    vt[4] = '{1'b1, 1'b1, 32'h1001_0014, 32'hFFFF_0000, 32'h3333_3333, 0, 32'hCAFE_F00D};
    vt[5] = '{1'b0, 1'b0, 32'h1001_00FC, 32'h0000_0000, 32'h0000_0001, 5, 32'h0000_0001};
    model_rd[0] = '0;
    model_rd[1] = '0;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {57'd0, m0_ack, m1_ack, m0_err, m1_err, bus_re, bus_we, owner}, 64'd0);
    chk("rst_m0_rdata", m0_rdata, 64'd0);
    chk("rst_m1_rdata", m1_rdata, 64'd0);
    chk("rst_bus_addr", bus_addr, 64'd0);
    chk("rst_bus_wdata", bus_wdata, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      xfer(vt[i].m, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].rdata, vt[i].dly,
           vt[i].exp_rd, 1'b0, vt[i].dly + 2, vt[i].dly + 1);
    end

`ifdef MEM_ARB_TIMEOUT_EN
    xfer(1'b0, 1'b0, 32'h1001_0040, 32'h0, 32'h9999_9999, -1,
         ARB_ERR_DATA, 1'b1, TO + 1, TO);
`endif

    // Stalled m0 access, then reset in the middle of ACCESS.
    @(negedge clk);
    ready_delay = -1;
    base = ack_seen;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h1001_0080;
`ifdef MEM_ARB_TIMEOUT_EN
    repeat (6) @(negedge clk);
`else
    repeat (100) @(negedge clk);
    chk("no_ack_when_stalled", ack_seen, base);
`endif
    chk("stalled_re_held", {63'd0, bus_re}, 64'd1);
    rst = 1'b1;
    m0_req = 1'b0;
    @(negedge clk);
    chk("mid_rst_strobes", {62'd0, bus_re, bus_we}, 64'd0);
    chk("mid_rst_acks", {62'd0, m0_ack, m1_ack}, 64'd0);
    rst = 1'b0;
    model_rd[0] = '0;
    model_rd[1] = '0;
    @(negedge clk);
    chk("post_rst_no_ack", {62'd0, m0_ack, m1_ack}, 64'd0);

    // Both request continuously: M0, M1, M0, M1 with one IDLE bubble between.
    ready_delay = 0;
    slave_data  = 32'h0A0B_0C0D;
    base = ack_seen;
    ack_cyc_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back('{m: i[0], rdata: 32'h0A0B_0C0D, err: 1'b0});
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h1001_0100;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h1001_0200;
    n = 0;
    while (ack_seen < base + 4 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    chk("rr_ack_count", ack_seen - base, 4);
    if (ack_cyc_q.size() == 4) begin
      for (int i = 1; i < 4; i++) chk("rr_spacing", ack_cyc_q[i] - ack_cyc_q[i-1], 3);
    end
    repeat (4) @(negedge clk);
    chk("idle_strobes", {62'd0, bus_re, bus_we}, 64'd0);
    chk("idle_owner_last", {63'd0, owner}, 64'd1);
    chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
